// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: datapath width, opcodes, and the fetch-buffer payload.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between imem responses and decode; flush empties it in one cycle.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !flush && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && !flush && (count != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

  // Storage is reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/riscv_fetch_unit.sv
// RV32I fetch: PC, single-outstanding imem handshake, buffered {pc, inst} to decode, redirect flush.
module riscv_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_t     state;
  fetch_state_t     state_n;
  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  pend_pc;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;
  logic             space_c;
  logic             grant_c;
  logic             push_c;
  logic             pop_c;
  logic             unused_ok;

  // An outstanding request reserves a slot; same-cycle pops are not credited.
  assign space_c  = (32'(count) + 32'(state != FETCH_IDLE)) < FIFO_DEPTH;
  assign imem_req = rst_n && space_c && !redirect && (state == FETCH_IDLE || imem_rvalid);
  assign imem_addr = fetch_pc;
  assign grant_c  = imem_req && imem_gnt;

  assign push_c     = imem_rvalid && (state == FETCH_WAIT) && !redirect;
  assign push_entry = '{pc: pend_pc, inst: imem_rdata};
  assign inst_valid = (count != '0);
  assign pop_c      = inst_valid && inst_ready;
  assign inst_pc    = head.pc;
  assign inst_data  = head.inst;
  assign unused_ok  = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH_IDLE;
      fetch_pc <= RESET_PC;
      pend_pc  <= '0;
    end else begin
      state <= state_n;
      if (redirect)     fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (grant_c) fetch_pc <= fetch_pc + XLEN'(4);
      if (grant_c)      pend_pc  <= fetch_pc;
    end
  end

  // Redirect turns a pending response into one to discard, unless it lands this cycle.
  always_comb begin
    state_n = state;
    if (redirect) begin
      if (imem_rvalid || state == FETCH_IDLE) state_n = FETCH_IDLE;
      else                                    state_n = FETCH_DROP;
    end else begin
      case (state)
        FETCH_IDLE: if (grant_c) state_n = FETCH_WAIT;
        FETCH_WAIT,
        FETCH_DROP: if (imem_rvalid) state_n = grant_c ? FETCH_WAIT : FETCH_IDLE;
        default:    state_n = FETCH_IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_c),
    .push_data(push_entry),
    .pop      (pop_c),
    .flush    (redirect),
    .head     (head),
    .count    (count)
  );

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Scoreboard bench for riscv_fetch_unit: reference PC model plus an imem model with random grant/latency.
module tb_riscv_fetch_unit;
  import riscv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;

  logic        b_req, b_gnt, b_rvalid, b_redirect, b_valid, b_ready;
  logic [31:0] b_addr, b_rdata, b_redirect_pc, b_data, b_pc;

  assign b_gnt         = 1'b1;
  assign b_ready       = 1'b1;
  assign b_redirect    = 1'b0;
  assign b_redirect_pc = 32'h0;

  riscv_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
  );

  riscv_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .imem_req(b_req), .imem_addr(b_addr), .imem_gnt(b_gnt),
    .imem_rvalid(b_rvalid), .imem_rdata(b_rdata),
    .redirect(b_redirect), .redirect_pc(b_redirect_pc),
    .inst_valid(b_valid), .inst_ready(b_ready),
    .inst_data(b_data), .inst_pc(b_pc)
  );

  // Zero-wait-grant, 1-cycle memory for the wrap-around instance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_rvalid <= 1'b0;
      b_rdata  <= 32'h0;
    end else begin
      b_rvalid <= b_req && b_gnt;
      b_rdata  <= ~b_addr;
    end
  end

  int           checks = 0;
  int           errors = 0;
  int           pops = 0;
  fetch_entry_t exp_q[$];
  logic [31:0]  ref_pc = 32'h0;
  bit           mem_pend = 0;
  logic [31:0]  mem_addr = 32'h0;
  int           mem_cnt = 0;
  int           gnt_wait = 0;
  int           gnt_max = 0;
  int           lat_min = 1;
  int           lat_max = 1;
  bit           ready_v = 1;
  bit           redir_v = 0;
  logic [31:0]  redir_pc_v = 32'h0;
  bit           stale_rv = 0;
  bit           stale_next = 0;
  bit           prev_redir = 0;
  bit           found;
  bit           did_reset = 0;
  bit           last_req, last_valid, last_b_req, last_b_valid;
  logic [31:0]  last_addr, last_pc, last_b_addr, last_b_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Response arriving in IDLE is only legal for the deliberate post-reset stale beat.
  always @(negedge clk) begin
    if (rst_n && imem_rvalid && !stale_rv)
      assert (dut.state != FETCH_IDLE) else $error("FAIL rvalid_in_idle addr=%h", mem_addr);
  end

  // One clock cycle: drive at edge+1, sample/score at edge+2, advance the models.
  task automatic step();
    fetch_entry_t e;
    stale_rv    = stale_next;
    imem_rvalid = stale_next || (mem_pend && mem_cnt == 0);
    imem_rdata  = stale_next ? 32'hDEAD_BEEF : (imem_rvalid ? mem_word(mem_addr) : 32'h0);
    inst_ready  = ready_v;
    redirect    = redir_v;
    redirect_pc = redir_pc_v;
    imem_gnt    = 1'b0;
    #1;
    if (prev_redir) check("valid_after_redirect", inst_valid, 0);
    if (imem_req) begin
      check("req_addr", imem_addr, ref_pc);
      if (gnt_wait == 0 && !stale_next) imem_gnt = 1'b1;
      else if (gnt_wait > 0)            gnt_wait--;
    end
    #1;
    last_req     = imem_req;
    last_addr    = imem_addr;
    last_valid   = inst_valid;
    last_pc      = inst_pc;
    last_b_req   = b_req;
    last_b_addr  = b_addr;
    last_b_valid = b_valid;
    last_b_pc    = b_pc;
    if (inst_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_nonempty", 0, 1);
      end else begin
        check("head_pc", inst_pc, exp_q[0].pc);
        check("head_data", inst_data, exp_q[0].inst);
        if (inst_ready) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
    end
    if (redirect) begin
      exp_q.delete();
      ref_pc = {redir_pc_v[31:2], 2'b00};
    end
    if (imem_rvalid)   mem_pend = 0;
    else if (mem_pend) mem_cnt--;
    if (imem_req && imem_gnt) begin
      e.pc   = ref_pc;
      e.inst = mem_word(ref_pc);
      exp_q.push_back(e);
      mem_pend = 1;
      mem_addr = imem_addr;
      mem_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
      gnt_wait = int'($urandom_range(gnt_max, 0));
      ref_pc   = ref_pc + 32'd4;
    end
    prev_redir = redirect;
    stale_next = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    #1;
    check("rst_req", imem_req, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_pc", inst_pc, 32'h0);
    check("rst_data", inst_data, 32'h0);
    repeat (cycles) @(posedge clk);
    #1;
    exp_q.delete();
    ref_pc     = 32'h0;
    gnt_wait   = 0;
    prev_redir = 0;
    redir_v    = 0;
    rst_n      = 1'b1;
  endtask

  task automatic wait_valid(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (last_valid) begin
        ok = 1;
        break;
      end
    end
    check("valid_timeout", ok, 1);
  endtask

  initial begin
    inst_ready = 1'b1;
    rst_n      = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);

    // Startup from 0 and wrap-around streaming on the deep instance.
    step();
    check("req_c0", last_req, 1);
    check("b_addr_c0", last_b_addr, 32'hFFFF_FFF8);
    step();
    check("req_c1", last_req, 1);
    check("b_addr_c1", last_b_addr, 32'hFFFF_FFFC);
    step();
    check("valid_c2", last_valid, 1);
    check("pc_c2", last_pc, 32'h0);
    check("b_addr_c2", last_b_addr, 32'h0);
    check("b_pc_c2", last_b_pc, 32'hFFFF_FFF8);
    step();
    check("valid_c3", last_valid, 1);
    check("pc_c3", last_pc, 32'h4);
    check("b_pc_c3", last_b_pc, 32'hFFFF_FFFC);
    step();
    check("b_valid_c4", last_b_valid, 1);
    check("b_pc_c4", last_b_pc, 32'h0);
    if (!last_valid) wait_valid(5);
    check("pc_third", last_pc, 32'h8);

    // Decode stall fills the buffer and stops fetching.
    ready_v = 0;
    repeat (10) step();
    check("stall_req", last_req, 0);
    check("stall_valid", last_valid, 1);
    check("stall_buffered", exp_q.size(), 2);
    ready_v = 1;
    repeat (8) step();

    // Redirect while a slow response is outstanding.
    lat_min = 3;
    lat_max = 3;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_pend && mem_cnt > 0) begin
        found = 1;
        break;
      end
      step();
    end
    check("redir_setup", found, 1);
    redir_v    = 1;
    redir_pc_v = 32'h0000_0103;
    step();
    redir_v = 0;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (last_req) begin
        found = 1;
        break;
      end
    end
    check("redir_req_seen", found, 1);
    check("redir_addr", last_addr, 32'h0000_0100);
    wait_valid(20);
    check("redir_first_pc", last_pc, 32'h0000_0100);

    // Redirect coinciding with a response and a pop.
    lat_min = 1;
    lat_max = 1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (inst_valid && mem_pend && mem_cnt == 0) begin
        found = 1;
        break;
      end
      step();
    end
    check("same_cycle_setup", found, 1);
    redir_v    = 1;
    redir_pc_v = 32'h0000_0200;
    step();
    redir_v = 0;
    step();
    check("sc_req_n1", last_req, 1);
    check("sc_addr_n1", last_addr, 32'h0000_0200);
    step();
    check("sc_valid_n2", last_valid, 0);
    step();
    check("sc_valid_n3", last_valid, 1);
    check("sc_pc_n3", last_pc, 32'h0000_0200);

    // Random grant delay / latency / stalls / redirects, with a mid-transaction reset.
    gnt_max = 3;
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 600; i++) begin
      ready_v    = ($urandom_range(3, 0) != 0);
      redir_v    = ($urandom_range(15, 0) == 0);
      redir_pc_v = $urandom();
      if (!did_reset && i >= 300 && mem_pend) begin
        did_reset = 1;
        do_reset(2);
        stale_next = 1;
        mem_pend   = 0;
        ready_v    = 1;
        redir_v    = 0;
        step();
        check("rst_first_req", last_req, 1);
        step();
        check("stale_ignored", last_valid, 0);
      end
      step();
    end
    check("mid_reset_done", did_reset, 1);

    redir_v = 0;
    ready_v = 1;
    gnt_max = 0;
    lat_max = 1;
    repeat (20) step();
    check("pops_seen", pops > 100, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
